ps2_input_arbiter: RTL



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rx.sv | 143 ++++++++++++++
 rtl/ps2_input_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the dual PS/2 input arbiter.
// Holds the receiver state encoding, source IDs and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic SRC_KBD   = 1'b0;
    localparam logic SRC_MOUSE = 1'b1;

    localparam int FRAME_DATA_BITS = 8;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// One PS/2 receiver: line synchronizers, clock glitch filter, frame FSM and timeout.
// Build option PS2_PARITY_CHECK_EN drops frames with bad odd parity at STOP.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          flt_q, flt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          valid_q, valid_d;

    logic fall;
    logic line_data;
    logic timed_out;
    logic frame_ok;

    assign line_data = data_sync_q[1];

    // The filtered level only flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        flt_d       = flt_q;
        flt_cnt_d   = '0;
        if (clk_sync_q[1] != flt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall      = flt_q & ~flt_d;
    assign timed_out = (state_q != RX_IDLE) && !fall && (timer_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            flt_q       <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            timer_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            flt_q       <= flt_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            valid_q     <= valid_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (state_q == RX_PARITY && fall) begin
            par_d = line_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign frame_ok = line_data && odd_parity_ok(shift_q, par_q);
`else
    assign frame_ok = line_data;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:   if (fall && !line_data) state_d = RX_DATA;
            RX_DATA:   if (fall && bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_d = RX_PARITY;
            RX_PARITY: if (fall) state_d = RX_STOP;
            RX_STOP:   if (fall) state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
        if (timed_out) begin
            state_d = RX_IDLE;
        end
    end

    // The completed byte stays in shift_q until the next start bit, so the
    // registered valid pulse can present it one cycle after STOP.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        valid_d   = 1'b0;
        timer_d   = (state_q == RX_IDLE || fall || timed_out) ? '0 : timer_q + 1'b1;
        unique case (state_q)
            RX_IDLE: begin
                if (fall) bit_cnt_d = '0;
            end
            RX_DATA: begin
                if (fall) begin
                    shift_d   = {line_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (fall && frame_ok) valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;

endmodule

// File: rtl/ps2_input_arbiter.sv
// Keyboard + mouse PS/2 receivers feeding per-source FIFOs and a round-robin output port.
// Build option PS2_PARITY_CHECK_EN (in ps2_rx) enables parity rejection.
module ps2_input_arbiter
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    input  logic       mouse_clk,
    input  logic       mouse_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic [1:0] ovf,
    input  logic       clr_ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]         rx_valid;
    logic [7:0]         rx_data [2];

    logic [7:0]         mem_q [2][FIFO_DEPTH];
    logic [1:0][PW-1:0] wptr_q, wptr_d;
    logic [1:0][PW-1:0] rptr_q, rptr_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         ovf_q, ovf_d;
    logic               last_q, last_d;
    logic               sel_q, sel_d;
    logic               lock_q, lock_d;

    logic [1:0]         nonempty;
    logic [1:0]         pop;
    logic [1:0]         push_ok;
    logic [1:0]         drop;
    logic               sel;
    logic               hs;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_kbd_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (kbd_clk),
        .ps2_data   (kbd_data),
        .byte_valid (rx_valid[SRC_KBD]),
        .byte_data  (rx_data[SRC_KBD])
    );

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_mouse_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (mouse_clk),
        .ps2_data   (mouse_data),
        .byte_valid (rx_valid[SRC_MOUSE]),
        .byte_data  (rx_data[SRC_MOUSE])
    );

    // A stalled offer keeps its grant; otherwise round-robin against the last handshake.
    always_comb begin
        nonempty[SRC_KBD]   = (cnt_q[SRC_KBD] != '0);
        nonempty[SRC_MOUSE] = (cnt_q[SRC_MOUSE] != '0);
        if (lock_q) begin
            sel = sel_q;
        end else if (&nonempty) begin
            sel = ~last_q;
        end else if (nonempty[SRC_KBD]) begin
            sel = SRC_KBD;
        end else if (nonempty[SRC_MOUSE]) begin
            sel = SRC_MOUSE;
        end else begin
            sel = SRC_KBD;
        end
        out_valid = nonempty[sel];
        out_src   = out_valid & sel;
        out_data  = out_valid ? mem_q[sel][rptr_q[sel]] : 8'h00;
        hs        = out_valid & out_ready;
        lock_d    = out_valid & ~out_ready;
        sel_d     = sel;
        last_d    = hs ? sel : last_q;
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        pop     = '0;
        push_ok = '0;
        drop    = '0;
        ovf_d   = clr_ovf ? 2'b00 : ovf_q;
        for (int s = 0; s < 2; s++) begin
            pop[s]     = hs && (sel == 1'(s));
            push_ok[s] = rx_valid[s] && ((cnt_q[s] != CW'(FIFO_DEPTH)) || pop[s]);
            drop[s]    = rx_valid[s] && !push_ok[s];
            if (push_ok[s]) wptr_d[s] = wptr_q[s] + 1'b1;
            if (pop[s])     rptr_d[s] = rptr_q[s] + 1'b1;
            cnt_d[s] = cnt_q[s] + CW'(push_ok[s]) - CW'(pop[s]);
            if (drop[s]) ovf_d[s] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
            last_q <= SRC_MOUSE;
            sel_q  <= SRC_KBD;
            lock_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            last_q <= last_d;
            sel_q  <= sel_d;
            lock_q <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push_ok[s]) mem_q[s][wptr_q[s]] <= rx_data[s];
        end
    end

    assign ovf = ovf_q;

endmodule
